ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_arb_rr2.sv | 22 ++
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared owner-FSM encoding and requester indices for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_e;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-requester arbitration decision: a lone requester wins; on contention
// the requester that did not win most recently is granted.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant, biased away from the last winner on contention
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_A] && req[REQ_B]) begin
            if (last == 1'(REQ_A)) gnt[REQ_B] = 1'b1;
            else                   gnt[REQ_A] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM with asynchronous read.
// Ownership can be locked across accesses; reads return one cycle later.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin contention
// resolution; without it port A always wins contention.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  lock_a,
    input  logic                  lock_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    owner_e                state, state_nxt;
    logic                  last_win;
    logic [1:0]            arb_gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Remember who transferred last so contention alternates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_win <= 1'(REQ_B);
        else if (xfer) last_win <= gnt_b ? 1'(REQ_B) : 1'(REQ_A);
    end
`else
    // Pinning the last winner to B makes the arbiter a fixed A-priority one
    assign last_win = 1'(REQ_B);
`endif

    ram_arb_rr2 u_rr2 (
        .req  ({req_b, req_a}),
        .last (last_win),
        .gnt  (arb_gnt)
    );

    // Grants: owner-only while locked, arbiter decision when idle, none in reset
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            case (state)
                OWN_A:   gnt_a = req_a;
                OWN_B:   gnt_b = req_b;
                default: begin
                    gnt_a = arb_gnt[REQ_A];
                    gnt_b = arb_gnt[REQ_B];
                end
            endcase
        end
    end

    assign xfer = gnt_a | gnt_b;

    // Next owner: a transfer with lock keeps ownership, anything else frees it
    always_comb begin
        state_nxt = IDLE;
        if (gnt_a)      state_nxt = lock_a ? OWN_A : IDLE;
        else if (gnt_b) state_nxt = lock_b ? OWN_B : IDLE;
    end

    // Owner state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RAM side follows the winner combinationally and holds between transfers
    assign ram_we    = (gnt_a & we_a) | (gnt_b & we_b);
    assign ram_addr  = gnt_a ? addr_a  : (gnt_b ? addr_b  : addr_q);
    assign ram_wdata = gnt_a ? wdata_a : (gnt_b ? wdata_b : wdata_q);

    // Capture the last transferred address/data for the hold behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (xfer) begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    // Read return: one-cycle valid pulse, data held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= gnt_a & ~we_a;
            rvalid_b <= gnt_b & ~we_b;
            if (gnt_a && !we_a) rdata_a <= ram_rdata;
            if (gnt_b && !we_b) rdata_b <= ram_rdata;
        end
    end

endmodule
